// File: rtl/aes_word_host.sv
// Word-serial host adapter for a 32-bit AES core: accepts a 128-bit block,
// feeds it to the core one word at a time and reassembles the 128-bit result.
module aes_word_host #(
  parameter int unsigned INIT_WAIT = 88,
  parameter logic [7:0]  DONE_CODE = 8'h10,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_text,
  input  logic [127:0] blk_key,
  input  logic         blk_dec,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_text,
  output logic         err_timeout,
  output logic         core_start,
  output logic [31:0]  core_data_in,
  output logic [127:0] core_key,
  output logic         core_selEncDec,
  input  logic [31:0]  core_data_out,
  input  logic [7:0]   core_signals
);

  localparam int unsigned CNT_MAX = (INIT_WAIT > TIMEOUT) ? INIT_WAIT : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1) + 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_START, S_LOAD, S_WAIT, S_READ, S_OUT
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [127:0]       text_q;
  logic               blk_ready_q;
  logic               res_valid_q;
  logic [127:0]       res_text_q;
  logic               err_q;
  logic               core_start_q;
  logic [31:0]        core_din_q;
  logic [127:0]       core_key_q;
  logic               core_sel_q;

  assign blk_ready      = blk_ready_q;
  assign res_valid      = res_valid_q;
  assign res_text       = res_text_q;
  assign err_timeout    = err_q;
  assign core_start     = core_start_q;
  assign core_data_in   = core_din_q;
  assign core_key       = core_key_q;
  assign core_selEncDec = core_sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      text_q       <= '0;
      blk_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_text_q   <= '0;
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
      core_din_q   <= '0;
      core_key_q   <= '0;
      core_sel_q   <= 1'b0;
    end else begin
      // Pulse-type outputs fall back to 0 unless a state drives them.
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
      core_din_q   <= '0;
      case (state_q)
        S_INIT: begin
          if (cnt_q == CNT_W'(INIT_WAIT)) begin
            state_q     <= S_IDLE;
            blk_ready_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            core_start_q <= (cnt_q < CNT_W'(2));
            cnt_q        <= cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (blk_valid && blk_ready_q) begin
            text_q       <= blk_text;
            core_key_q   <= blk_key;
            core_sel_q   <= blk_dec;
            blk_ready_q  <= 1'b0;
            core_start_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == CNT_W'(1)) begin
            core_din_q <= text_q[127:96];
            cnt_q      <= '0;
            state_q    <= S_LOAD;
          end else begin
            core_start_q <= 1'b1;
            cnt_q        <= cnt_q + 1'b1;
          end
        end
        S_LOAD: begin
          // Words 1..3 follow word 0, then one zero word before waiting.
          case (cnt_q[2:0])
            3'd0:    core_din_q <= text_q[95:64];
            3'd1:    core_din_q <= text_q[63:32];
            3'd2:    core_din_q <= text_q[31:0];
            default: core_din_q <= '0;
          endcase
          if (cnt_q == CNT_W'(4)) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          // A DONE_CODE on the final allowed cycle still wins over the abort.
          if (core_signals == DONE_CODE) begin
            res_text_q[127:96] <= core_data_out;
            cnt_q              <= '0;
            state_q            <= S_READ;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q       <= 1'b1;
            blk_ready_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_READ: begin
          case (cnt_q[1:0])
            2'd0:    res_text_q[95:64] <= core_data_out;
            2'd1:    res_text_q[63:32] <= core_data_out;
            default: res_text_q[31:0]  <= core_data_out;
          endcase
          if (cnt_q == CNT_W'(2)) begin
            res_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_OUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            blk_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_host.sv
// Directed bench for aes_word_host with a behavioural word-serial core model
// that returns known FIPS-197 answers for the reference key/text pair.
module tb_aes_word_host;

  localparam int          INIT_WAIT = 88;
  localparam int          TIMEOUT   = 255;
  localparam logic [7:0]  DONE      = 8'h10;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] TX3 = 128'hdeadbeef00000000ffffffff12345678;
  localparam logic [127:0] RX3 = 128'h21524110ffffffff00000000edcba987;

  logic         clk = 1'b0, reset = 1'b0;
  logic         blk_valid = 1'b0, blk_ready, blk_dec = 1'b0;
  logic [127:0] blk_text = '0, blk_key = '0, res_text, core_key;
  logic         res_valid, res_ready = 1'b0, err_timeout;
  logic         core_start, core_selEncDec;
  logic [31:0]  core_data_in, core_data_out = '0;
  logic [7:0]   core_signals = '0;

  aes_word_host #(.INIT_WAIT(INIT_WAIT), .DONE_CODE(DONE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_text(blk_text),
    .blk_key(blk_key), .blk_dec(blk_dec),
    .res_valid(res_valid), .res_ready(res_ready), .res_text(res_text),
    .err_timeout(err_timeout),
    .core_start(core_start), .core_data_in(core_data_in), .core_key(core_key),
    .core_selEncDec(core_selEncDec), .core_data_out(core_data_out),
    .core_signals(core_signals)
  );

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Core model: words follow the falling edge of start; answer after m_lat cycles.
  int           m_t = -1, m_lat = 5;
  bit           m_mute = 1'b0;
  logic         m_prev_start = 1'b0;
  logic [127:0] m_in = '0, m_res = '0;

  function automatic logic [127:0] ref_core(input logic [127:0] t, input logic [127:0] k, input logic d);
    if (k == KEY && !d && t == PT) return CT;
    if (k == KEY &&  d && t == CT) return PT;
    return ~t;
  endfunction

  always @(negedge clk) begin
    core_signals  = 8'h00;
    core_data_out = 32'h0;
    if (reset) begin
      m_t          = -1;
      m_prev_start = 1'b0;
    end else begin
      if (m_prev_start && !core_start) begin
        m_t          = 0;
        m_in[127:96] = core_data_in;
      end else if (m_t >= 0) begin
        m_t++;
        if (m_t <= 3) m_in[32*(3-m_t) +: 32] = core_data_in;
        if (!m_mute && m_t == 3 + m_lat) begin
          m_res         = ref_core(m_in, core_key, core_selEncDec);
          core_signals  = DONE;
          core_data_out = m_res[127:96];
        end else if (!m_mute && m_t > 3 + m_lat && m_t <= 6 + m_lat) begin
          core_signals  = 8'h01;
          core_data_out = m_res[32*(6+m_lat-m_t) +: 32];
        end
        if (m_t >= 6 + m_lat) m_t = -1;
      end
      m_prev_start = core_start;
    end
  end

  logic [127:0] last_res = '0;

  task automatic init_check(input string tag);
    int first, nstart;
    logic [7:0] smask;
    first = -1; nstart = 0; smask = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (core_start) begin
        nstart++;
        if (c < 8) smask[c] = 1'b1;
      end
      if (blk_ready) begin
        first = c;
        break;
      end
    end
    blk_valid = 1'b0;
    chk({tag, "_rdy_cycle"}, first, INIT_WAIT);
    chk({tag, "_start_mask"}, smask, 8'h03);
    chk({tag, "_start_cnt"}, nstart, 2);
  endtask

  task automatic run_block(input string tag, input logic [127:0] text, input logic dec,
                           input int lat, input bit mute, input bit exp_to,
                           input logic [127:0] exp, input int hold);
    int seen;
    bit sel_ok, stable;
    logic [127:0] held;
    m_lat = lat; m_mute = mute;
    for (int i = 0; i < 400 && !blk_ready; i++) @(negedge clk);
    chk({tag, "_rdy"}, blk_ready, 1);
    blk_text = text; blk_key = KEY; blk_dec = dec; blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    chk({tag, "_acc"}, {blk_ready, core_start, core_selEncDec}, {1'b0, 1'b1, dec});
    chk({tag, "_key"}, core_key, KEY);
    seen = -1; sel_ok = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (core_selEncDec !== dec || core_key !== KEY) sel_ok = 1'b0;
      if (res_valid || err_timeout) begin
        seen = i;
        break;
      end
    end
    chk({tag, "_lat"}, seen, exp_to ? 7 + TIMEOUT : 9 + lat);
    chk({tag, "_sel"}, sel_ok, 1);
    if (exp_to) begin
      chk({tag, "_err"}, {err_timeout, res_valid, blk_ready}, 3'b101);
      chk({tag, "_keep"}, res_text, last_res);
      @(negedge clk);
      chk({tag, "_pulse"}, {err_timeout, res_valid}, 2'b00);
    end else begin
      chk({tag, "_res"}, res_text, exp);
      chk({tag, "_load"}, m_in, text);
      held = res_text; stable = 1'b1;
      blk_valid = 1'b1; blk_text = ~text;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!res_valid || res_text !== held || blk_ready) stable = 1'b0;
      end
      chk({tag, "_hold"}, stable, 1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0; blk_valid = 1'b0;
      chk({tag, "_release"}, {res_valid, blk_ready, core_start}, 3'b010);
      last_res = held;
    end
  endtask

  initial begin
    bit found;
    #2 reset = 1'b1;
    #2;
    chk("rst0_out", {res_valid, blk_ready, err_timeout, core_start, core_selEncDec}, 0);
    chk("rst0_text", res_text, 0);
    @(negedge clk); @(negedge clk);
    blk_valid = 1'b1; blk_text = PT; blk_key = KEY;
    reset = 1'b0;
    init_check("init1");

    run_block("enc",   PT,  1'b0, 5,   1'b0, 1'b0, CT,  20);
    run_block("dec",   CT,  1'b1, 3,   1'b0, 1'b0, PT,  3);
    run_block("edge",  TX3, 1'b0, 256, 1'b0, 1'b0, RX3, 2);
    run_block("mute",  PT,  1'b0, 5,   1'b1, 1'b1, '0,  0);
    run_block("late",  CT,  1'b1, 257, 1'b0, 1'b1, '0,  0);

    // Reset in the middle of LOAD, on the third text word.
    m_lat = 5; m_mute = 1'b0;
    for (int i = 0; i < 400 && !blk_ready; i++) @(negedge clk);
    blk_text = PT; blk_key = KEY; blk_dec = 1'b0; blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_data_in == 32'h8899aabb) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_at_w2", found, 1);
    reset = 1'b1;
    #1;
    chk("rst_out", {res_valid, blk_ready, err_timeout, core_start, core_selEncDec}, 0);
    chk("rst_text", res_text, 0);
    chk("rst_key", core_key, 0);
    chk("rst_din", core_data_in, 0);
    @(negedge clk);
    blk_valid = 1'b1;
    reset = 1'b0;
    init_check("init2");
    last_res = '0;
    run_block("enc2", PT, 1'b0, 5, 1'b0, 1'b0, CT, 2);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/aes_word_host.md
AES_WORD_HOST -- requirements
Module: aes_word_host

Parameters
REQ-001 The block SHALL have parameter INIT_WAIT, default 88, giving the number of cycles after reset before the first block is accepted.
REQ-002 The block SHALL have parameter DONE_CODE, default 8'h10, the core signals value marking the first output word.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of WAIT cycles before abort.

Interface
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 blk_valid  in  1  host block request.
REQ-007 blk_ready  out  1  block accepted on cycle with blk_valid&blk_ready.
REQ-008 blk_text  in  128  input text (plaintext or ciphertext).
REQ-009 blk_key  in  128  cipher key.
REQ-010 blk_dec  in  1  1=decrypt, 0=encrypt.
REQ-011 res_valid  out  1  result available.
REQ-012 res_ready  in  1  host consumes result.
REQ-013 res_text  out  128  result text.
REQ-014 err_timeout  out  1  one-cycle pulse on WAIT abort.
REQ-015 core_start  out  1  drives core start.
REQ-016 core_data_in  out  32  drives core data_in.
REQ-017 core_key  out  128  drives core key_in.
REQ-018 core_selEncDec  out  1  drives core selEncDec.
REQ-019 core_data_out  in  32  core data_out.
REQ-020 core_signals  in  8  core signals.

Function
REQ-021 All outputs SHALL be registered; states SHALL be INIT, IDLE, START, LOAD, WAIT, READ, OUT.
REQ-022 INIT: counter runs INIT_WAIT cycles with core_start=1 for the first 2 cycles and 0 thereafter, then the block SHALL go to IDLE.
REQ-023 IDLE: blk_ready=1; on handshake, the block SHALL latch text/key/dec and go to START.
REQ-024 core_key and core_selEncDec SHALL update only at handshake and hold stable until the next handshake.
REQ-025 START: core_start=1 for exactly 2 cycles, then LOAD.
REQ-026 LOAD: core_start=0; core_data_in SHALL be text[127:96], [95:64], [63:32], [31:0] on 4 consecutive cycles, then 32'h0, then WAIT.
REQ-027 core_data_in SHALL be 32'h0 in every state other than LOAD.
REQ-028 WAIT: when core_signals==DONE_CODE, the block SHALL capture core_data_out into res_text[127:96] and go to READ.
REQ-029 READ: the next 3 cycles SHALL capture into [95:64], [63:32], [31:0] unconditionally, then go to OUT.
REQ-030 OUT: res_valid=1, res_text SHALL be held stable until res_ready; on res_ready the block SHALL clear res_valid and go to IDLE.
REQ-031 Simultaneous res_ready and blk_valid SHALL NOT accept a block in the same cycle; acceptance occurs in IDLE only.
REQ-032 WAIT cycle counter: if TIMEOUT cycles elapse without DONE_CODE, the block SHALL pulse err_timeout, skip OUT, and go to IDLE with res_text unchanged.
REQ-033 A DONE_CODE match on the same cycle the counter reaches TIMEOUT SHALL count as a match (no error).
REQ-034 blk_ready SHALL be 0 in all states except IDLE.

Reset
REQ-035 On reset assertion, all outputs SHALL immediately be 0 (res_text=0, core_key=0, core_data_in=0, core_start=0), state=INIT and counters cleared, including mid-LOAD/WAIT/OUT; after release, INIT SHALL restart from the beginning.

Verification
REQ-036 Reset, hold blk_valid=1 -> blk_ready first 1 at cycle INIT_WAIT after release; core_start=1 on cycles 0-1 only.
REQ-037 Encrypt key 000102..0f, text 00112233445566778899aabbccddeeff, core model -> core_data_in 00112233, 44556677, 8899aabb, ccddeeff on consecutive cycles; res_text=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-038 Decrypt, same key, text 69c4e0d8...c55a, blk_dec=1 -> core_selEncDec=1 throughout; res_text=00112233445566778899aabbccddeeff.
REQ-039 Core model never emits 8'h10 -> err_timeout pulse after 255 WAIT cycles, res_valid stays 0, blk_ready returns 1.
REQ-040 Hold res_ready=0 for 20 cycles in OUT -> res_valid and res_text stable, blk_ready=0; res_ready=1 -> IDLE next cycle.
REQ-041 Assert reset during LOAD word 2 -> all outputs 0 immediately; after release, INIT repeats and a full vector completes correctly.
